// File: rtl/sram64kb_ctrl.sv
// sram64kb_ctrl: valid/ready byte read/write controller for a 64 KB bank of 128 x 512x8 SRAM macros
module sram64kb_ctrl #(
    parameter int RD_WAIT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic         i_req_we,
    input  logic [15:0]  i_req_addr,
    input  logic [7:0]   i_req_wdata,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_we,
    output logic [7:0]   o_rsp_rdata,
    output logic [8:0]   o_mem_addr,
    output logic         o_mem_ce,
    output logic         o_mem_web,
    output logic [127:0] o_mem_oeb,
    output logic [127:0] o_mem_csb,
    output logic [7:0]   o_mem_idata,
    input  logic [7:0]   i_mem_odata
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_SAMPLE, S_RESP} state_t;

    localparam logic [2:0] WAIT_LAST = 3'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

    state_t       r_state;
    state_t       w_next;
    logic         r_we;
    logic [6:0]   r_idx;
    logic [2:0]   r_cnt;
    logic [7:0]   r_rsp_rdata;
    logic         r_mem_ce;
    logic         r_mem_web;
    logic [127:0] r_mem_oeb;
    logic [127:0] r_mem_csb;
    logic [8:0]   r_mem_addr;
    logic [7:0]   r_mem_idata;
    logic         w_accept;
    logic         w_we;
    logic [6:0]   w_idx;
    logic         w_sel;
    logic [127:0] w_onehot_n;

    // The macro-side flops are loaded from the upcoming state, so the transaction
    // fields come straight from the request port on the accept edge.
    assign w_accept   = (r_state == S_IDLE) && i_req_valid;
    assign w_we       = w_accept ? i_req_we : r_we;
    assign w_idx      = w_accept ? i_req_addr[15:9] : r_idx;
    assign w_sel      = w_next inside {S_SETUP, S_STROBE, S_WAIT, S_SAMPLE};
    assign w_onehot_n = ~(128'd1 << w_idx);

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_we    = r_we;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mem_ce    = r_mem_ce;
    assign o_mem_web   = r_mem_web;
    assign o_mem_oeb   = r_mem_oeb;
    assign o_mem_csb   = r_mem_csb;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_idata = r_mem_idata;

    // Next-state decode of the access sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_req_valid ? S_SETUP : S_IDLE;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = r_we ? S_RESP : ((RD_WAIT > 0) ? S_WAIT : S_SAMPLE);
            S_WAIT:   w_next = (r_cnt == WAIT_LAST) ? S_SAMPLE : S_WAIT;
            S_SAMPLE: w_next = S_RESP;
            S_RESP:   w_next = i_rsp_ready ? S_IDLE : S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register, latched transaction, wait counter and response data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 3'd1 : 3'd0;
            if (w_accept) begin
                r_we  <= i_req_we;
                r_idx <= i_req_addr[15:9];
            end
            if (w_accept && i_req_we)
                r_rsp_rdata <= '0;
            else if (r_state == S_SAMPLE)
                r_rsp_rdata <= i_mem_odata;
        end
    end

    // Registered macro controls; decode happens before the flop so the bank sees clean edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_ce    <= 1'b0;
            r_mem_web   <= 1'b1;
            r_mem_oeb   <= '1;
            r_mem_csb   <= '1;
            r_mem_addr  <= '0;
            r_mem_idata <= '0;
        end else begin
            r_mem_ce  <= (w_next == S_STROBE);
            r_mem_web <= !(w_we && (w_next == S_SETUP || w_next == S_STROBE));
            r_mem_csb <= w_sel ? w_onehot_n : '1;
            r_mem_oeb <= (w_sel && !w_we) ? w_onehot_n : '1;
            if (w_accept) begin
                r_mem_addr  <= i_req_addr[8:0];
                r_mem_idata <= i_req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_sram64kb_ctrl.sv
// tb_sram64kb_ctrl: scoreboard bench for sram64kb_ctrl with a behavioural 128-macro bank per instance
module tb_sram64kb_ctrl;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic         clk;
    logic         rst_n;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [2:0]   req_we;
    logic [15:0]  req_addr [3];
    logic [7:0]   req_wdata [3];
    logic [2:0]   rsp_valid;
    logic [2:0]   rsp_ready;
    logic [2:0]   rsp_we;
    logic [7:0]   rsp_rdata [3];
    logic [8:0]   maddr [3];
    logic [2:0]   ce;
    logic [2:0]   web;
    logic [127:0] oeb [3];
    logic [127:0] csb [3];
    logic [7:0]   idata [3];
    logic [7:0]   odata [3];

    logic [7:0]   bank [3][65536];
    logic [7:0]   shadow [3][65536];
    logic [7:0]   dout [3][128];
    logic [10:0]  q [$];
    int           n_tests = 0;
    int           n_fail = 0;

    // Instance 0 waits 1 cycle, instance 1 none, instance 2 the maximum of 7.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram64kb_ctrl #(.RD_WAIT(g == 0 ? 1 : (g == 1 ? 0 : 7))) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]), .i_req_we(req_we[g]),
            .i_req_addr(req_addr[g]), .i_req_wdata(req_wdata[g]),
            .o_rsp_valid(rsp_valid[g]), .i_rsp_ready(rsp_ready[g]), .o_rsp_we(rsp_we[g]),
            .o_rsp_rdata(rsp_rdata[g]),
            .o_mem_addr(maddr[g]), .o_mem_ce(ce[g]), .o_mem_web(web[g]),
            .o_mem_oeb(oeb[g]), .o_mem_csb(csb[g]), .o_mem_idata(idata[g]),
            .i_mem_odata(odata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macros clock on the CE pulse: selected macro writes or loads its output register.
    always @(posedge clk)
        for (int g = 0; g < 3; g++)
            if (ce[g])
                for (int i = 0; i < 128; i++)
                    if (!csb[g][i]) begin
                        if (!web[g]) bank[g][{i[6:0], maddr[g]}] <= idata[g];
                        else dout[g][i] <= bank[g][{i[6:0], maddr[g]}];
                    end

    // Bank read bus: OR of every macro whose output enable is low.
    always_comb
        for (int g = 0; g < 3; g++) begin
            odata[g] = 8'h00;
            for (int i = 0; i < 128; i++)
                if (!oeb[g][i]) odata[g] = odata[g] | dout[g][i];
        end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int rw_of(input int k);
        return k == 0 ? 1 : (k == 1 ? 0 : 7);
    endfunction

    // Response handshakes pop the scoreboard; one-hot selects are checked every cycle.
    always @(negedge clk) begin
        logic [10:0] e;
        for (int g = 0; g < 3; g++) begin
            chk("csb_onehot", 128'($countones(~csb[g]) <= 1), 128'd1);
            chk("oeb_onehot", 128'($countones(~oeb[g]) <= 1), 128'd1);
            if (rst_n && rsp_valid[g] && rsp_ready[g]) begin
                if (q.size() == 0) chk("spurious_rsp", 128'(g), 128'hff);
                else begin
                    e = q.pop_front();
                    chk("rsp_inst", 128'(g), 128'(e[10:9]));
                    chk("rsp_we", 128'(rsp_we[g]), 128'(e[8]));
                    chk("rsp_rdata", 128'(rsp_rdata[g]), 128'(e[7:0]));
                end
            end
        end
    end

    task automatic chk_rst(input int k);
        chk("rst_ctrl", 128'({req_ready[k], rsp_valid[k], rsp_we[k], rsp_rdata[k], ce[k], web[k], maddr[k], idata[k]}),
            128'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 8'h00}));
        chk("rst_csb", csb[k], ONES);
        chk("rst_oeb", oeb[k], ONES);
    endtask

    task automatic do_txn(input int k, input logic we, input logic [15:0] a, input logic [7:0] d, input int hold);
        int n;
        int lat;
        logic [127:0] sel_n;
        logic [7:0] exp_rd;
        sel_n = ~(128'd1 << a[15:9]);
        req_we[k] = we;
        req_addr[k] = a;
        req_wdata[k] = d;
        req_valid[k] = 1'b1;
        rsp_ready[k] = (hold == 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[k] && n < 50);
        if (!req_ready[k]) begin
            chk("accept_timeout", 128'd0, 128'd1);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        exp_rd = we ? 8'h00 : shadow[k][a];
        q.push_back({2'(k), we, exp_rd});
        if (we) shadow[k][a] = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat <= 2) begin
                chk("sel_csb", csb[k], sel_n);
                chk("sel_oeb", oeb[k], we ? ONES : sel_n);
                chk("sel_web", 128'(web[k]), 128'(!we));
                chk("sel_ce", 128'(ce[k]), 128'(lat == 2));
                chk("sel_addr", 128'(maddr[k]), 128'(a[8:0]));
                if (we) chk("sel_idata", 128'(idata[k]), 128'(d));
            end else if (!rsp_valid[k]) begin
                chk("wait_ce", 128'(ce[k]), 128'd0);
                chk("wait_oeb", oeb[k], sel_n);
            end
        end while (!rsp_valid[k] && lat < 40);
        chk($sformatf("latency_k%0d_we%0d", k, we), 128'(lat), 128'(we ? 3 : 4 + rw_of(k)));
        chk("resp_csb", csb[k], ONES);
        chk("resp_oeb", oeb[k], ONES);
        chk("resp_ctl", 128'({web[k], ce[k], req_ready[k]}), 128'(3'b100));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                req_valid[k] = 1'b1;
                req_we[k] = 1'b1;
                req_addr[k] = 16'h1234;
                @(negedge clk);
                chk("hold_rsp", 128'({rsp_valid[k], rsp_we[k], rsp_rdata[k]}), 128'({1'b1, we, exp_rd}));
                chk("hold_req_ready", 128'(req_ready[k]), 128'd0);
            end
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_we = '0;
        rsp_ready = '1;
        for (int k = 0; k < 3; k++) begin
            req_addr[k] = '0;
            req_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_rst(k);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_txn(0, 1'b1, 16'h0000, 8'hA5, 0);
        do_txn(0, 1'b0, 16'h0000, 8'h00, 0);
        do_txn(0, 1'b1, 16'hFFFF, 8'h3C, 0);
        do_txn(0, 1'b1, 16'h0200, 8'hC3, 0);
        do_txn(0, 1'b0, 16'hFFFF, 8'h00, 0);
        do_txn(0, 1'b0, 16'h0200, 8'h00, 0);
        do_txn(0, 1'b1, 16'h01FF, 8'h5A, 0);
        do_txn(0, 1'b0, 16'h01FF, 8'h00, 0);

        for (int i = 0; i < 128; i++) do_txn(0, 1'b1, {i[6:0], 9'(i * 5 + 1)}, i[7:0], 0);
        for (int i = 0; i < 128; i++) do_txn(0, 1'b0, {i[6:0], 9'(i * 5 + 1)}, 8'h00, 0);

        do_txn(0, 1'b0, 16'hFFFF, 8'h00, 10);

        // Abort a read in its WAIT cycle with an asynchronous reset.
        req_we[0] = 1'b0;
        req_addr[0] = 16'h0200;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("abort_ready", 128'(req_ready[0]), 128'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_wait", oeb[0], ~(128'd1 << 1));
        rst_n = 1'b0;
        #1;
        chk_rst(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 128'(rsp_valid[0]), 128'd0);
        end
        @(posedge clk); #1;
        do_txn(0, 1'b0, 16'h0000, 8'h00, 0);
        do_txn(0, 1'b0, 16'h0200, 8'h00, 0);

        for (int k = 1; k < 3; k++) begin
            do_txn(k, 1'b1, 16'h0000, 8'hA5, 0);
            do_txn(k, 1'b0, 16'h0000, 8'h00, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
